// File: rtl/invader_formation_if.sv
// Bundle between the invader formation controller and its surroundings:
// raster position and frame strobe in, kill requests in, renderer drive out.
interface invader_formation_if #(
    parameter int INVADERS_H = 11,
    parameter int INVADERS_V = 5
);
    logic                             frame_start;
    logic [9:0]                       pixel_x;
    logic [9:0]                       pixel_y;
    logic                             kill_valid;
    logic [2:0]                       kill_row;
    logic [3:0]                       kill_col;
    logic [INVADERS_V-1:0]            row_start;
    logic [9:0]                       spr_x;
    logic [9:0]                       formation_y;
    logic [INVADERS_V*INVADERS_H-1:0] row_mask;
    logic                             all_dead;
    logic                             landed;

    // Video timing / collision side
    modport master (
        output frame_start, pixel_x, pixel_y, kill_valid, kill_row, kill_col,
        input  row_start, spr_x, formation_y, row_mask, all_dead, landed
    );

    // Formation controller side
    modport slave (
        input  frame_start, pixel_x, pixel_y, kill_valid, kill_row, kill_col,
        output row_start, spr_x, formation_y, row_mask, all_dead, landed
    );
endinterface

// File: rtl/invader_formation.sv
// Invader formation controller: owns position, march direction and alive
// masks, pulses per-row start strobes to the sprite renderers, applies kills
// and marches the formation during vertical blank.
module invader_formation #(
    parameter int INVADERS_H  = 11,
    parameter int INVADERS_V  = 5,
    parameter int SPRITE_W_PX = 26,
    parameter int SPRITE_H_PX = 16,
    parameter int OFFSET_H    = 32,
    parameter int OFFSET_V    = 24,
    parameter int X_INIT      = 100,
    parameter int Y_INIT      = 64,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 8,
    parameter int X_MIN       = 16,
    parameter int X_MAX       = 623,
    parameter int Y_LIMIT     = 400,
    parameter int MOVE_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    invader_formation_if.slave bus
);
    localparam int MASK_W = INVADERS_V * INVADERS_H;
    localparam int IDX_W  = $clog2(MASK_W);
    localparam int CNT_W  = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;

    localparam logic [1:0] WAIT_FRAME = 2'd0;
    localparam logic [1:0] SCAN       = 2'd1;
    localparam logic [1:0] MOVE       = 2'd2;
    localparam logic [1:0] CHECK      = 2'd3;

    logic [1:0]            state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [9:0]            x_reg;
    logic [9:0]            y_reg;
    logic                  dir_left_reg;
    logic [MASK_W-1:0]     mask_reg;
    logic [MASK_W-1:0]     mask_next;
    logic [MASK_W-1:0]     snap_reg;
    logic [3:0]            col_reg;
    logic [3:0]            l_reg;
    logic [3:0]            r_reg;
    logic [2:0]            b_reg;
    logic                  occ_reg;
    logic [INVADERS_V-1:0] row_start_reg;
    logic                  all_dead_reg;
    logic                  landed_reg;

    logic [INVADERS_V-1:0] row_hit;
    logic [INVADERS_V-1:0] col_bits;
    logic [2:0]            col_bottom;
    logic                  kill_hit;
    logic [IDX_W-1:0]      kill_idx;
    logic [10:0]           right_edge;
    logic [10:0]           left_edge;
    logic [10:0]           bottom_edge;

    // Per-row raster match and scan-column extraction from the snapshot
    genvar gi;
    generate
        for (gi = 0; gi < INVADERS_V; gi++) begin : g_row
            logic [INVADERS_H-1:0] snap_row;
            assign snap_row     = snap_reg[gi*INVADERS_H +: INVADERS_H];
            assign col_bits[gi] = snap_row[col_reg];
            assign row_hit[gi]  = (bus.pixel_x == 10'd0)
                               && ({1'b0, bus.pixel_y} == ({1'b0, y_reg} + 11'(gi*OFFSET_V)))
                               && (|mask_reg[gi*INVADERS_H +: INVADERS_H]);
        end
    endgenerate

    // Lowest (highest-index) occupied row within the column being scanned
    always_comb begin
        col_bottom = 3'd0;
        for (int r = 0; r < INVADERS_V; r++) begin
            if (col_bits[r]) col_bottom = 3'(r);
        end
    end

    // Kill decode: out-of-range indices never touch the mask
    assign kill_hit = bus.kill_valid
                   && (int'(bus.kill_row) < INVADERS_V)
                   && (int'(bus.kill_col) < INVADERS_H);
    assign kill_idx = IDX_W'(bus.kill_row) * IDX_W'(INVADERS_H) + IDX_W'(bus.kill_col);

    // Next mask: clear the addressed bit (a dead bit simply stays dead)
    always_comb begin
        mask_next = mask_reg;
        if (kill_hit) mask_next[kill_idx] = 1'b0;
    end

    // Edge positions in 11 bits so the comparisons never wrap
    assign right_edge  = {1'b0, x_reg} + 11'(r_reg) * 11'(OFFSET_H) + 11'(SPRITE_W_PX - 1 + STEP_X);
    assign left_edge   = {1'b0, x_reg} + 11'(l_reg) * 11'(OFFSET_H);
    assign bottom_edge = {1'b0, y_reg} + 11'(b_reg) * 11'(OFFSET_V) + 11'(SPRITE_H_PX - 1);

    // Alive mask and its registered all-dead flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg     <= '1;
            all_dead_reg <= 1'b0;
        end else begin
            mask_reg     <= mask_next;
            all_dead_reg <= (mask_reg == '0);
        end
    end

    // Row-start strobes, suppressed once the game is over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_start_reg <= '0;
        end else begin
            row_start_reg <= row_hit & {INVADERS_V{~(all_dead_reg | landed_reg)}};
        end
    end

    // March FSM: frame divider, column scan, move/reverse, landing check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= WAIT_FRAME;
            cnt_reg      <= '0;
            x_reg        <= 10'(X_INIT);
            y_reg        <= 10'(Y_INIT);
            dir_left_reg <= 1'b0;
            snap_reg     <= '0;
            col_reg      <= 4'd0;
            l_reg        <= 4'd0;
            r_reg        <= 4'd0;
            b_reg        <= 3'd0;
            occ_reg      <= 1'b0;
            landed_reg   <= 1'b0;
        end else begin
            case (state_reg)
                WAIT_FRAME: begin
                    if (bus.frame_start && !all_dead_reg && !landed_reg) begin
                        if (cnt_reg == CNT_W'(MOVE_FRAMES - 1)) begin
                            cnt_reg   <= '0;
                            snap_reg  <= mask_reg;
                            col_reg   <= 4'd0;
                            l_reg     <= 4'd0;
                            r_reg     <= 4'd0;
                            b_reg     <= 3'd0;
                            occ_reg   <= 1'b0;
                            state_reg <= SCAN;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (|col_bits) begin
                        if (!occ_reg) l_reg <= col_reg;
                        r_reg   <= col_reg;
                        occ_reg <= 1'b1;
                        if (col_bottom > b_reg) b_reg <= col_bottom;
                    end
                    if (col_reg == 4'(INVADERS_H - 1)) begin
                        state_reg <= MOVE;
                    end else begin
                        col_reg <= col_reg + 4'd1;
                    end
                end
                MOVE: begin
                    // An empty snapshot (kill racing the frame) leaves the formation put
                    if (occ_reg) begin
                        if (!dir_left_reg && (right_edge > 11'(X_MAX))) begin
                            y_reg        <= y_reg + 10'(STEP_Y);
                            dir_left_reg <= 1'b1;
                        end else if (dir_left_reg && (left_edge < 11'(X_MIN + STEP_X))) begin
                            y_reg        <= y_reg + 10'(STEP_Y);
                            dir_left_reg <= 1'b0;
                        end else if (dir_left_reg) begin
                            x_reg <= x_reg - 10'(STEP_X);
                        end else begin
                            x_reg <= x_reg + 10'(STEP_X);
                        end
                    end
                    state_reg <= CHECK;
                end
                default: begin
                    if (occ_reg && (bottom_edge >= 11'(Y_LIMIT))) landed_reg <= 1'b1;
                    state_reg <= WAIT_FRAME;
                end
            endcase
        end
    end

    assign bus.row_start   = row_start_reg;
    assign bus.spr_x       = x_reg;
    assign bus.formation_y = y_reg;
    assign bus.row_mask    = mask_reg;
    assign bus.all_dead    = all_dead_reg;
    assign bus.landed      = landed_reg;

endmodule

// File: tb/tb_invader_formation.sv
// Directed bench for invader_formation with a one-frame march period.
module tb_invader_formation;
    localparam int H = 11;
    localparam int V = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    int          total = 0;
    int          bad = 0;
    logic [54:0] exp_mask;
    logic [54:0] mask_now;
    int          ex, ey, nfr;
    bit          eleft, eland;

    invader_formation_if #(.INVADERS_H(H), .INVADERS_V(V)) bus ();

    invader_formation #(.MOVE_FRAMES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        $display("chk %-14s obs=%0h exp=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        repeat (14) tick();
    endtask

    task automatic kill(input int r, input int c);
        bus.kill_valid = 1'b1;
        bus.kill_row   = 3'(r);
        bus.kill_col   = 4'(c);
        tick();
        bus.kill_valid = 1'b0;
    endtask

    // One raster position at x=0, then x=1 to confirm the pulse is one cycle
    task automatic rowchk(input int y, input logic [4:0] exp);
        bus.pixel_x = 10'd0;
        bus.pixel_y = 10'(y);
        tick();
        chk($sformatf("row_start@%0d", y), bus.row_start, exp);
        bus.pixel_x = 10'd1;
        tick();
        chk($sformatf("row_end@%0d", y), bus.row_start, 5'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.pixel_x     = 10'd1;
        bus.pixel_y     = 10'd0;
        bus.kill_valid  = 1'b0;
        bus.kill_row    = 3'd0;
        bus.kill_col    = 4'd0;
        exp_mask        = '1;
        #12;
        chk("rst spr_x", bus.spr_x, 100);
        chk("rst form_y", bus.formation_y, 64);
        chk("rst mask", bus.row_mask, exp_mask);
        chk("rst row_start", bus.row_start, 0);
        chk("rst all_dead", bus.all_dead, 0);
        chk("rst landed", bus.landed, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Row strobes at formation_y + 24r, none off-row
        for (int r = 0; r < V; r++) rowchk(64 + 24 * r, 5'(1 << r));
        rowchk(65, 5'd0);

        // Three marches right
        frame(); chk("march1 x", bus.spr_x, 104);
        frame(); chk("march2 x", bus.spr_x, 108);
        frame(); chk("march3 x", bus.spr_x, 112);
        chk("march3 y", bus.formation_y, 64);

        // Remove columns 7..10 everywhere, rightmost occupied column becomes 6
        for (int r = 0; r < V; r++) begin
            for (int c = 7; c < H; c++) begin
                kill(r, c);
                exp_mask[r*H + c] = 1'b0;
            end
        end
        tick();
        chk("cols7-10 mask", bus.row_mask, exp_mask);
        // 404+6*32+25+4 = 625 > 623 reverses; 400 gives 621 and still steps
        repeat (73) frame();
        chk("pre-rev x", bus.spr_x, 404);
        chk("pre-rev y", bus.formation_y, 64);
        frame();
        chk("rev x", bus.spr_x, 404);
        chk("rev y", bus.formation_y, 72);
        frame();
        chk("post-rev x", bus.spr_x, 400);
        chk("post-rev y", bus.formation_y, 72);

        // Wipe row 2
        for (int c = 0; c < H; c++) begin
            kill(2, c);
            exp_mask[2*H + c] = 1'b0;
        end
        tick();
        mask_now = bus.row_mask;
        chk("row2 bits", mask_now[22 +: 11], 0);
        chk("row2 mask", bus.row_mask, exp_mask);
        rowchk(72 + 48, 5'd0);
        rowchk(72 + 72, 5'b01000);
        rowchk(72, 5'b00001);

        // Out-of-range and duplicate kills leave the mask alone
        kill(5, 0);  tick(); chk("kill r5 ign", bus.row_mask, exp_mask);
        kill(2, 11); tick(); chk("kill c11 ign", bus.row_mask, exp_mask);
        kill(0, 8);  tick(); chk("kill dup ign", bus.row_mask, exp_mask);
        kill(1, 3);  exp_mask[1*H + 3] = 1'b0;
        tick(); chk("kill (1,3)", bus.row_mask, exp_mask);

        // March until row 4 bottom reaches 400: L=0, R=6, B=4 from here on
        ex = 400; ey = 72; eleft = 1'b1; eland = 1'b0; nfr = 0;
        while (!eland && nfr < 3500) begin
            frame();
            nfr++;
            if (!eleft && (ex + 6*32 + 25 + 4 > 623)) begin
                ey += 8; eleft = 1'b0 ^ 1'b1;
            end else if (eleft && (ex < 16 + 4)) begin
                ey += 8; eleft = 1'b0;
            end else if (eleft) begin
                ex -= 4;
            end else begin
                ex += 4;
            end
            if (ey + 4*24 + 15 >= 400) eland = 1'b1;
        end
        chk("landed", bus.landed, 1);
        chk("land y", bus.formation_y, 296);
        chk("land x", bus.spr_x, 10'(ex));
        frame();
        chk("landed sticky", bus.landed, 1);
        chk("landed frz y", bus.formation_y, 296);
        chk("landed frz x", bus.spr_x, 10'(ex));
        rowchk(296, 5'd0);

        // Fresh start, then kill all 55 one per cycle
        rst_n = 1'b0;
        #3;
        chk("rst2 landed", bus.landed, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                bus.kill_valid = 1'b1;
                bus.kill_row   = 3'(r);
                bus.kill_col   = 4'(c);
                tick();
            end
        end
        bus.kill_valid = 1'b0;
        chk("killall mask", bus.row_mask, 0);
        chk("killall dead0", bus.all_dead, 0);
        tick();
        chk("killall dead1", bus.all_dead, 1);
        frame();
        chk("dead frz x", bus.spr_x, 100);
        rowchk(64, 5'd0);

        // Asynchronous reset in the middle of a scan
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        frame();
        chk("pre-scan x", bus.spr_x, 104);
        kill(0, 0);
        tick();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async x", bus.spr_x, 100);
        chk("async y", bus.formation_y, 64);
        chk("async mask", bus.row_mask, {55{1'b1}});
        chk("async rs", bus.row_start, 0);
        chk("async dead", bus.all_dead, 0);
        chk("async land", bus.landed, 0);
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) tick();
        chk("no partial x", bus.spr_x, 100);
        chk("no partial y", bus.formation_y, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
